display_scanner: RTL

Time-multiplexed driver for an N-digit common-anode seven-segment display. It sits directly upstream of the seven_segment decoder and feeds it one 4-bit digit code at a time, together with an active-low digit-select one-hot. A load handshake captures a new multi-digit value, which is applied only at a frame boundary so the display never shows a torn value. Optional leading-zero blanking is supported.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/refresh_divider.sv | 30 +++
 rtl/display_scanner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display scanner.
package disp_pkg;

  localparam int DEFAULT_NUM_DIGITS = 4;
  localparam int MAX_DIGITS         = 32;

  // Active-low select with every digit switched off; slice to the digit count in use.
  localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/refresh_divider.sv
// Prescaler producing a one-cycle tick every REFRESH_DIV clocks to pace the digit scan.
module refresh_divider #(
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    cnt_d = cnt_q + DIV_W'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed N-digit seven-segment scanner with frame-aligned value load
// and optional leading-zero blanking.
module display_scanner
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    blank_lz_i,
  output logic                    ready_o,
  output logic [3:0]              num_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    frame_o
);

  localparam int                VAL_W    = 4 * NUM_DIGITS;
  localparam int                IDX_W    = clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = DIGIT_OFF[NUM_DIGITS-1:0];

  logic                  tick;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_next;
  logic [VAL_W-1:0]      shown_q, shown_d;
  logic [VAL_W-1:0]      pend_val_q, pend_val_d;
  logic                  pending_q, pending_d;
  logic [3:0]            num_q, num_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frame_q, frame_d;
  logic                  commit;
  logic [VAL_W-1:0]      eff_val;
  logic [NUM_DIGITS-1:0] blank_mask;

  refresh_divider #(
    .REFRESH_DIV (REFRESH_DIV),
    .DIV_W       (DIV_W)
  ) u_refresh_divider (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    commit   = tick && (idx_next == '0);
    // At a commit edge digit 0 must already reflect the newly loaded value.
    eff_val  = (commit && pending_q) ? pend_val_q : shown_q;
  end

  // Digit k>0 is blanked when it and every more-significant nibble are zero.
  always_comb begin : lz_blanking
    logic run_zero;
    run_zero   = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run_zero      = run_zero && (eff_val[4*k +: 4] == 4'h0);
      blank_mask[k] = blank_lz_i && run_zero;
    end
  end

  always_comb begin
    idx_d      = idx_q;
    num_d      = num_q;
    sel_d      = sel_q;
    frame_d    = 1'b0;
    shown_d    = shown_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;

    if (tick) begin
      idx_d   = idx_next;
      frame_d = (idx_next == '0);
      sel_d   = SEL_OFF;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_next == IDX_W'(k)) begin
          num_d = eff_val[4*k +: 4];
          if (!blank_mask[k]) sel_d[k] = 1'b0;
        end
      end
    end

    if (commit && pending_q) begin
      shown_d   = pend_val_q;
      pending_d = 1'b0;
    end

    // A load can only be accepted while nothing is pending, so it never races a commit.
    if (load_i && !pending_q) begin
      pend_val_d = value_i;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= LAST_IDX;
      shown_q    <= '0;
      pend_val_q <= '0;
      pending_q  <= 1'b0;
      num_q      <= 4'h0;
      sel_q      <= SEL_OFF;
      frame_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      shown_q    <= shown_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      num_q      <= num_d;
      sel_q      <= sel_d;
      frame_q    <= frame_d;
    end
  end

  assign ready_o     = ~pending_q;
  assign num_o       = num_q;
  assign digit_sel_o = sel_q;
  assign frame_o     = frame_q;

endmodule
